// File: rtl/mem_arbiter_ram.sv
// Multi-channel word memory: round-robin valid/ready arbitration, fixed-latency
// response pipeline, alignment/range exceptions and LR/SC reservation tracking.
module mem_arbiter_ram #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_CH-1:0]        in_req_valid,
    output logic [NUM_CH-1:0]        in_req_ready,
    input  logic [NUM_CH-1:0]        in_req_write,
    input  logic [NUM_CH-1:0]        in_req_lr,
    input  logic [NUM_CH-1:0]        in_req_sc,
    input  logic [NUM_CH*ADDR_W-1:0] in_req_addr,
    input  logic [NUM_CH*DATA_W-1:0] in_req_data,
    output logic [NUM_CH-1:0]        out_resp_valid,
    output logic [NUM_CH*DATA_W-1:0] out_resp_data,
    output logic [NUM_CH-1:0]        out_resp_exc_valid,
    output logic [NUM_CH*4-1:0]      out_resp_exc_code
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   NUM_CH_W = (PTR_W + 1)'(NUM_CH);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);

    typedef struct packed {
        logic              valid;
        logic [PTR_W-1:0]  ch;
        logic [DATA_W-1:0] data;
        logic              exc_valid;
        logic [3:0]        exc_code;
    } resp_t;

    // Arbitration state and reservation
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  res_valid_q, res_valid_d;
    logic [PTR_W-1:0]      res_ch_q, res_ch_d;
    logic [DEPTH_LOG2-1:0] res_idx_q, res_idx_d;

    // First pipeline stage; load data joins it from the registered RAM read
    logic             s0_valid_q;
    logic [PTR_W-1:0] s0_ch_q;
    logic             s0_use_rd_q;
    logic             s0_sc_fail_q;
    logic             s0_exc_q;
    logic [3:0]       s0_code_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic                  gnt_found;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W:0]        cand;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_write;
    logic                  sel_lr;
    logic                  sel_sc;
    logic [IDX_W-1:0]      word_idx;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                  misalign;
    logic                  out_of_range;
    logic                  exc;
    logic [3:0]            exc_code;
    logic                  ok_acc;
    logic                  res_hit;
    logic                  sc_fail;
    logic                  mem_we;
    resp_t                 head;
    resp_t                 out_r;

    // Walk offsets from high to low so the smallest offset from the pointer wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (cand >= NUM_CH_W) begin
                cand = cand - NUM_CH_W;
            end
            if (in_req_valid[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign in_req_ready = gnt_found ? (NUM_CH'(1) << gnt_idx) : '0;

    assign sel_addr  = in_req_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
    assign sel_wdata = in_req_data[int'(gnt_idx) * DATA_W +: DATA_W];
    assign sel_write = in_req_write[gnt_idx];
    assign sel_lr    = in_req_lr[gnt_idx];
    assign sel_sc    = in_req_sc[gnt_idx];

    assign word_idx     = sel_addr[ADDR_W-1:OFF_W];
    assign mem_idx      = word_idx[DEPTH_LOG2-1:0];
    assign misalign     = |sel_addr[OFF_W-1:0];
    assign out_of_range = word_idx > LAST_IDX;
    assign exc          = misalign | out_of_range;

    always_comb begin
        exc_code = 4'd0;
        if (misalign) begin
            exc_code = sel_write ? 4'd6 : 4'd4;
        end else if (out_of_range) begin
            exc_code = sel_write ? 4'd7 : 4'd5;
        end
    end

    assign ok_acc  = gnt_found & ~exc;
    assign res_hit = res_valid_q && (res_ch_q == gnt_idx) && (res_idx_q == mem_idx);
    assign sc_fail = sel_write & sel_sc & ~res_hit;
    assign mem_we  = ok_acc & sel_write & ~sc_fail;

    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_ch_d    = res_ch_q;
        res_idx_d   = res_idx_q;
        if (gnt_found) begin
            ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        end
        if (ok_acc) begin
            if (!sel_write && sel_lr) begin
                res_valid_d = 1'b1;
                res_ch_d    = gnt_idx;
                res_idx_d   = mem_idx;
            end else if (sel_write && sel_sc) begin
                res_valid_d = 1'b0;
            end else if (sel_write && res_valid_q && (res_idx_q == mem_idx)) begin
                res_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr_q        <= '0;
            res_valid_q  <= 1'b0;
            res_ch_q     <= '0;
            res_idx_q    <= '0;
            s0_valid_q   <= 1'b0;
            s0_ch_q      <= '0;
            s0_use_rd_q  <= 1'b0;
            s0_sc_fail_q <= 1'b0;
            s0_exc_q     <= 1'b0;
            s0_code_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            res_valid_q  <= res_valid_d;
            res_ch_q     <= res_ch_d;
            res_idx_q    <= res_idx_d;
            s0_valid_q   <= gnt_found;
            s0_ch_q      <= gnt_idx;
            s0_use_rd_q  <= ok_acc & ~sel_write;
            s0_sc_fail_q <= ok_acc & sc_fail;
            s0_exc_q     <= gnt_found & exc;
            s0_code_q    <= gnt_found ? exc_code : 4'd0;
        end
    end

    // Block RAM: no reset on contents or the read register
    always_ff @(posedge CLK) begin
        if (mem_we && !RESET) begin
            mem_q[mem_idx] <= sel_wdata;
        end
        if (gnt_found) begin
            rd_data_q <= mem_q[mem_idx];
        end
    end

    always_comb begin
        head.valid     = s0_valid_q;
        head.ch        = s0_ch_q;
        head.data      = s0_use_rd_q ? rd_data_q : {{(DATA_W-1){1'b0}}, s0_sc_fail_q};
        head.exc_valid = s0_exc_q;
        head.exc_code  = s0_code_q;
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign out_r = head;
        end else begin : g_pipe
            resp_t pipe_q [LATENCY-1];
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= head;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign out_r = pipe_q[LATENCY-2];
        end
    endgenerate

    // Only the originating channel's lanes carry the response
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        logic hit;
        assign hit = out_r.valid && (out_r.ch == PTR_W'(gi));
        assign out_resp_valid[gi]                  = hit;
        assign out_resp_data[gi*DATA_W +: DATA_W]  = hit ? out_r.data : '0;
        assign out_resp_exc_valid[gi]              = hit & out_r.exc_valid;
        assign out_resp_exc_code[gi*4 +: 4]        = hit ? out_r.exc_code : 4'd0;
    end

endmodule

// File: tb/tb_mem_arbiter_ram.sv
// Directed bench: four instances sharing stimulus, differing only in LATENCY (1..4).
module tb_mem_arbiter_ram;

    localparam int NC = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic CLK = 1'b0;
    logic RESET;
    logic [NC-1:0]    valid, write, lr, sc;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;

    logic [NC-1:0]    rdy   [4];
    logic [NC-1:0]    rv    [4];
    logic [NC-1:0]    rexv  [4];
    logic [NC*DW-1:0] rdata [4];
    logic [NC*4-1:0]  rcode [4];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        mem_arbiter_ram #(
            .NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(10), .LATENCY(gi + 1)
        ) u_dut (
            .CLK(CLK), .RESET(RESET),
            .in_req_valid(valid), .in_req_ready(rdy[gi]),
            .in_req_write(write), .in_req_lr(lr), .in_req_sc(sc),
            .in_req_addr(addr), .in_req_data(wdata),
            .out_resp_valid(rv[gi]), .out_resp_data(rdata[gi]),
            .out_resp_exc_valid(rexv[gi]), .out_resp_exc_code(rcode[gi])
        );
    end

    function automatic logic [75:0] obs(input int i);
        return {rv[i], rdata[i], rexv[i], rcode[i]};
    endfunction

    function automatic logic [75:0] expv(input int ch, input logic [31:0] d, input logic e,
                                         input logic [3:0] code);
        logic [1:0]  v;
        logic [63:0] dd;
        logic [1:0]  ev;
        logic [7:0]  cc;
        v = '0; dd = '0; ev = '0; cc = '0;
        v[ch] = 1'b1;
        dd[ch*32 +: 32] = d;
        ev[ch] = e;
        cc[ch*4 +: 4] = code;
        return {v, dd, ev, cc};
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        valid = '0; write = '0; lr = '0; sc = '0; addr = '0; wdata = '0;
    endtask

    task automatic drive(input int ch, input logic w, input logic l, input logic s,
                         input logic [31:0] a, input logic [31:0] d);
        idle();
        valid[ch] = 1'b1;
        write[ch] = w;
        lr[ch]    = l;
        sc[ch]    = s;
        addr[ch*AW +: AW]  = a;
        wdata[ch*DW +: DW] = d;
    endtask

    // One isolated request; returns the LATENCY=2 instance's output on its response cycle
    task automatic single(input int ch, input logic w, input logic l, input logic s,
                          input logic [31:0] a, input logic [31:0] d, output logic [75:0] o);
        drive(ch, w, l, s, a, d);
        step();
        idle();
        step();
        o = obs(1);
        $display("txn ch=%0d wr=%0d lr=%0d sc=%0d addr=%h data=%h resp=%h", ch, w, l, s, a, d, o);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle();
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs(i) !== 76'b0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got %h want 0", i, obs(i));
            end
        end
        valid = 2'b11;
        #1;
        checks++;
        if (rdy[1] !== 2'b01) begin errors++; $display("FAIL reset_ready_both got %b want 01", rdy[1]); end
        valid = 2'b10;
        #1;
        checks++;
        if (rdy[1] !== 2'b10) begin errors++; $display("FAIL reset_ready_ch1 got %b want 10", rdy[1]); end
        idle();
        @(negedge CLK);
        RESET = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        logic [1:0] e;
        idle();
        valid = 2'b11;
        addr  = {32'h40, 32'h40};
        for (int c = 0; c < 6; c++) begin
            #1;
            e = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (rdy[1] !== e) begin errors++; $display("FAIL fair_grant%0d got %b want %b", c, rdy[1], e); end
            step();
        end
        idle();
        repeat (5) step();
    endtask

    task automatic test_basic();
        logic [75:0] e;
        drive(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
        #1;
        checks++;
        if (rdy[1] !== 2'b10) begin errors++; $display("FAIL basic_ready got %b want 10", rdy[1]); end
        step();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        step();
        e = expv(1, 32'h0, 1'b0, 4'd0);
        checks++;
        if (obs(1) !== e) begin errors++; $display("FAIL basic_store_resp got %h want %h", obs(1), e); end
        idle();
        step();
        e = expv(0, 32'hDEADBEEF, 1'b0, 4'd0);
        checks++;
        if (obs(1) !== e) begin errors++; $display("FAIL basic_load_resp got %h want %h", obs(1), e); end
        step();
        checks++;
        if (obs(1) !== 76'b0) begin errors++; $display("FAIL basic_quiet got %h want 0", obs(1)); end
    endtask

    task automatic test_exceptions();
        logic [75:0] o, e;
        single(0, 1, 0, 0, 32'h0, 32'h11111111, o); e = expv(0, 0, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_st0 got %h want %h", o, e); end
        single(0, 0, 0, 0, 32'h41, 32'h0, o); e = expv(0, 0, 1, 4);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_ld_misal got %h want %h", o, e); end
        single(0, 1, 0, 0, 32'h42, 32'hFFFFFFFF, o); e = expv(0, 0, 1, 6);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_st_misal got %h want %h", o, e); end
        single(0, 1, 0, 0, 32'hFFC, 32'h12345678, o); e = expv(0, 0, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_st_last got %h want %h", o, e); end
        single(0, 0, 0, 0, 32'h1000, 32'h0, o); e = expv(0, 0, 1, 5);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_ld_range got %h want %h", o, e); end
        single(0, 1, 0, 0, 32'h1000, 32'hBAD, o); e = expv(0, 0, 1, 7);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_st_range got %h want %h", o, e); end
        single(0, 0, 0, 0, 32'h0, 32'h0, o); e = expv(0, 32'h11111111, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_mem0_kept got %h want %h", o, e); end
        single(0, 0, 0, 0, 32'h40, 32'h0, o); e = expv(0, 32'hDEADBEEF, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_mem40_kept got %h want %h", o, e); end
        single(0, 0, 0, 0, 32'hFFC, 32'h0, o); e = expv(0, 32'h12345678, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL exc_ld_last got %h want %h", o, e); end
    endtask

    task automatic test_lrsc();
        logic [75:0] o, e;
        single(1, 0, 1, 0, 32'h80, 32'h0, o);
        checks++; if ({o[75:74], o[9:8]} !== 4'b1000) begin errors++; $display("FAIL lr1 got %h want valid ch1", o); end
        single(1, 1, 0, 1, 32'h80, 32'h5, o); e = expv(1, 0, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL sc1_pass got %h want %h", o, e); end
        single(1, 0, 0, 0, 32'h80, 32'h0, o); e = expv(1, 5, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL sc1_mem got %h want %h", o, e); end
        single(1, 1, 0, 1, 32'h80, 32'h6, o); e = expv(1, 1, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL sc2_fail got %h want %h", o, e); end
        single(1, 0, 0, 0, 32'h80, 32'h0, o); e = expv(1, 5, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL sc2_nowrite got %h want %h", o, e); end
        single(1, 0, 1, 0, 32'h80, 32'h0, o); e = expv(1, 5, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL lr3 got %h want %h", o, e); end
        single(0, 1, 0, 0, 32'h80, 32'h9, o); e = expv(0, 0, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL st_ch0 got %h want %h", o, e); end
        single(1, 1, 0, 1, 32'h80, 32'h7, o); e = expv(1, 1, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL sc3_fail got %h want %h", o, e); end
        single(1, 0, 0, 0, 32'h80, 32'h0, o); e = expv(1, 9, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL sc3_mem got %h want %h", o, e); end
        single(1, 0, 1, 0, 32'h80, 32'h0, o);
        single(0, 1, 0, 0, 32'h84, 32'h3, o);
        single(1, 1, 0, 1, 32'h80, 32'hA, o); e = expv(1, 0, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL sc4_other_word got %h want %h", o, e); end
        single(1, 0, 0, 0, 32'h80, 32'h0, o); e = expv(1, 32'hA, 0, 0);
        checks++; if (o !== e) begin errors++; $display("FAIL sc4_mem got %h want %h", o, e); end
    endtask

    task automatic test_reset_midflight();
        logic [75:0] e;
        idle();
        repeat (4) step();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        step();
        idle();
        RESET = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs(i) !== 76'b0) begin errors++; $display("FAIL rst_mid_out inst=%0d got %h want 0", i, obs(i)); end
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs(2) !== 76'b0) begin errors++; $display("FAIL rst_hold%0d got %h want 0", c, obs(2)); end
        end
        RESET = 1'b0;
        step();
        checks++;
        if (obs(2) !== 76'b0) begin errors++; $display("FAIL rst_release got %h want 0", obs(2)); end
        valid = 2'b11;
        addr  = {32'h40, 32'h40};
        #1;
        checks++;
        if (rdy[2] !== 2'b01) begin errors++; $display("FAIL rst_ptr got %b want 01", rdy[2]); end
        step();
        idle();
        checks++;
        if (obs(2) !== 76'b0) begin errors++; $display("FAIL rst_lat_e0 got %h want 0", obs(2)); end
        step();
        checks++;
        if (obs(2) !== 76'b0) begin errors++; $display("FAIL rst_lat_e1 got %h want 0", obs(2)); end
        step();
        e = expv(0, 32'hDEADBEEF, 0, 0);
        checks++;
        if (obs(2) !== e) begin errors++; $display("FAIL rst_lat_e2 got %h want %h", obs(2), e); end
    endtask

    task automatic test_latency();
        logic [75:0] o, e;
        logic [31:0] vals [4];
        int inst [2];
        int lat [2];
        int j;
        vals[0] = 32'hA1A1A1A1; vals[1] = 32'hB2B2B2B2; vals[2] = 32'hC3C3C3C3; vals[3] = 32'hD4D4D4D4;
        inst[0] = 0; lat[0] = 1; inst[1] = 3; lat[1] = 4;
        for (int k = 0; k < 4; k++) begin
            single(k % 2, 1, 0, 0, 32'h100 + 32'(4 * k), vals[k], o);
        end
        idle();
        repeat (4) step();
        for (int s = 0; s < 8; s++) begin
            if (s < 4) drive(s % 2, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(4 * s), 32'h0);
            else idle();
            step();
            for (int n = 0; n < 2; n++) begin
                j = s - (lat[n] - 1);
                e = (j >= 0 && j < 4) ? expv(j % 2, vals[j], 0, 0) : 76'b0;
                o = obs(inst[n]);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL lat%0d_edge%0d got %h want %h", lat[n], s, o, e);
                end
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        idle();
        test_reset();
        test_fairness();
        test_basic();
        test_exceptions();
        test_lrsc();
        test_reset_midflight();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
